sum_display_scanner: RTL
========================

# sum_display_scanner

Downstream display stage for the pipelined weighted-sum datapath. It accepts a 13-bit unsigned sum with a valid strobe and converts it to four BCD digits using an iterative shift-add-3 (double-dabble) engine. It then time-multiplexes the four digits onto a common-anode four-digit seven-segment display. The digit register holds the last completed conversion, so the display stays stable while a new sum converts.

## Interface
- REFRESH_BITS, 18: width of the refresh counter. The top 2 bits select the digit, so each digit is lit for 2^(REFRESH_BITS-2) cycles. Minimum value is 3.
- BLANK_LZ, 1: 1 blanks leading zeros. The ones digit is never blanked.
- clk  input  1  single clock; all state updates on its rising edge.
- rest  input  1  asynchronous, active-low reset.
- in_value  input  13  unsigned sum to display, range 0..8191.
- in_valid  input  1  one-cycle strobe qualifying in_value.
- busy  output  1  high while a conversion is in progress.
- bcd_out  output  16  last completed result as {thousands, hundreds, tens, ones}, 4 bits each.
- Anode  output  4  active-low digit enables. Anode[3] is thousands, Anode[0] is ones.
- LED_out  output  7  active-low segments {a,b,c,d,e,f,g}, with a on LED_out[6].

## Operation
- FSM states:
  - IDLE: no conversion running.
  - SHIFT: runs 13 iterations. Each iteration adds 3 to every BCD nibble that is ≥5, then shifts {bcd, bin} left by 1.
  - DONE: single cycle. Writes the 16-bit BCD result to bcd_out and to the display digit register.
- IDLE → SHIFT: on in_valid. in_value is loaded into the shifter, BCD is cleared, and the iteration counter is set to 0.
- SHIFT → DONE: after the 13th shift.
- DONE → SHIFT: taken if a pending value exists or in_valid is high in that cycle.
- DONE → IDLE: taken otherwise.
- Pending slot (one deep):
  - in_valid in SHIFT or DONE stores in_value into the pending slot and sets the pending flag. A later strobe overwrites the earlier one, so the newest value wins.
  - in_valid in DONE is both the pending source and the next load. It has priority over any older pending value, which is discarded.
  - The pending flag is cleared when its value is loaded.
- Scanner: the refresh counter free-runs and wraps from all-ones to 0. The digit index is counter[REFRESH_BITS-1:REFRESH_BITS-2]:
  - 0 selects thousands, Anode=0111.
  - 1 selects hundreds, Anode=1011.
  - 2 selects tens, Anode=1101.
  - 3 selects ones, Anode=1110.
- Segment codes for digits 0–9: 0000001, 1001111, 0010010, 0000110, 1001100, 0100100, 0100000, 0001111, 0000000, 0000100.
- Nibble values 10–15 cannot occur. If one is forced, LED_out shows 1111111.
- Blanking with BLANK_LZ=1: a digit is blanked when it and all higher digits are 0. Exception: the ones digit is never blanked.
  - A blanked digit keeps its Anode active and drives LED_out=1111111.
- Anode and LED_out are registered outputs. They are decoded from the counter and digit register values of the previous cycle.

## Timing
- Reset asserted (rest low) forces, asynchronously:
  - state=IDLE, busy=0, pending=0, bcd_out=0.
  - digit register=0, refresh counter=0.
  - Anode=1111, LED_out=1111111.
- After reset release:
  - The first active-edge registers Anode=0111.
  - With BLANK_LZ=1, display 0 blanks thousands, hundreds and tens, and shows "0" on ones.
- Reset mid-conversion aborts the conversion, clears the pending value, and leaves bcd_out=0.
- Conversion latency, with in_valid sampled at edge k:
  - busy rises after edge k.
  - Shifts occur at edges k+1..k+13.
  - DONE is entered at edge k+13.
  - bcd_out and the digit register update at edge k+14.
  - busy falls after edge k+14 unless back-to-back operation applies.
  - Total latency is 14 cycles.
- Back-to-back: if a pending value exists or in_valid is high at edge k+14, busy stays high and the next result lands at edge k+28. Throughput is one result per 14 cycles.
- The display change appears on LED_out one cycle after the digit register update, for the digit currently selected.
- Refresh counter wrap: digit 3 → digit 0 with no gap cycle. Exactly one Anode bit is low at all times after the first post-reset edge.

## Test plan
- Reset: hold rest low for 5 cycles with in_valid toggling. Required: busy=0, bcd_out=0000, Anode=1111, LED_out=1111111. After release, Anode=0111.
- Single conversion: in_value=8191 strobed at edge k. Required: busy high for edges k..k+14, bcd_out=0x8191 at edge k+14. With REFRESH_BITS=4, the scan shows 0000000, 1001111, 0000100, 1001111 on Anode 0111, 1011, 1101, 1110.
- Leading zeros with BLANK_LZ=1: 7 → thousands, hundreds and tens show 1111111, ones shows 0001111. 1005 → all four digits lit, showing 1, 0, 0, 5.
- Pending overwrite:
  - Strobe 1234, then strobe 42 at k+3 and 900 at k+7. Required: bcd_out=0x1234 at k+14 and 0x0900 at k+28; 42 is never displayed; busy stays continuously high through k+28.
  - Separately, strobe at the DONE edge (k+13): the new value takes priority over the older pending value.
- Reset mid-conversion: strobe 5555, pull rest low at k+6. Required: immediate busy=0 and bcd_out=0. No update occurs after release, and a new strobe of 10 yields 0x0010 14 cycles later.
- Sweep: in_value 0..8191 with REFRESH_BITS=4. Required: bcd_out matches the decimal value every time, with no nibble above 9.

Source files
------------

// File: rtl/sum_display_scanner.sv
// Converts a 13-bit sum to four BCD digits with an iterative double-dabble engine
// and scans them onto a common-anode four-digit seven-segment display.
//   state | meaning
//   IDLE  | no conversion running
//   SHIFT | 13 add-3/shift iterations in progress
//   DONE  | publish result; reload from in_valid or the pending slot
module sum_display_scanner #(
    parameter int REFRESH_BITS = 18,
    parameter bit BLANK_LZ     = 1'b1
) (
    input  logic        clk,
    input  logic        rest,
    input  logic [12:0] in_value,
    input  logic        in_valid,
    output logic        busy,
    output logic [15:0] bcd_out,
    output logic [3:0]  Anode,
    output logic [6:0]  LED_out
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_nxt;
    logic [15:0] bcd_q, bcd_nxt;
    logic [12:0] bin_q, bin_nxt;
    logic [3:0]  iter_q, iter_nxt;
    logic [12:0] pend_val_q, pend_val_nxt;
    logic        pend_q, pend_nxt;
    logic        publish;
    logic [15:0] adj;
    logic [15:0] disp_q;

    logic [REFRESH_BITS-1:0] refresh_q;
    logic [1:0]  idx;
    logic [3:0]  nib;
    logic        blank;
    logic [3:0]  anode_nxt;
    logic [6:0]  led_nxt;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            adj[i*4 +: 4] = (bcd_q[i*4 +: 4] >= 4'd5) ? bcd_q[i*4 +: 4] + 4'd3 : bcd_q[i*4 +: 4];
        end
    end

    always_comb begin
        state_nxt    = state;
        bcd_nxt      = bcd_q;
        bin_nxt      = bin_q;
        iter_nxt     = iter_q;
        pend_val_nxt = pend_val_q;
        pend_nxt     = pend_q;
        publish      = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    bin_nxt   = in_value;
                    bcd_nxt   = 16'h0000;
                    iter_nxt  = 4'd0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                bcd_nxt  = {adj[14:0], bin_q[12]};
                bin_nxt  = {bin_q[11:0], 1'b0};
                iter_nxt = iter_q + 4'd1;
                if (iter_q == 4'd12) begin
                    state_nxt = DONE;
                end
                if (in_valid) begin
                    pend_val_nxt = in_value;
                    pend_nxt     = 1'b1;
                end
            end
            DONE: begin
                publish  = 1'b1;
                bcd_nxt  = 16'h0000;
                iter_nxt = 4'd0;
                // A strobe arriving now is newer than anything pending, so it wins.
                if (in_valid) begin
                    bin_nxt   = in_value;
                    pend_nxt  = 1'b0;
                    state_nxt = SHIFT;
                end else if (pend_q) begin
                    bin_nxt   = pend_val_q;
                    pend_nxt  = 1'b0;
                    state_nxt = SHIFT;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state      <= IDLE;
            bcd_q      <= 16'h0000;
            bin_q      <= 13'd0;
            iter_q     <= 4'd0;
            pend_val_q <= 13'd0;
            pend_q     <= 1'b0;
            bcd_out    <= 16'h0000;
            disp_q     <= 16'h0000;
        end else begin
            state      <= state_nxt;
            bcd_q      <= bcd_nxt;
            bin_q      <= bin_nxt;
            iter_q     <= iter_nxt;
            pend_val_q <= pend_val_nxt;
            pend_q     <= pend_nxt;
            if (publish) begin
                bcd_out <= bcd_q;
                disp_q  <= bcd_q;
            end
        end
    end

    assign busy = (state != IDLE);

    always_comb begin
        idx       = refresh_q[REFRESH_BITS-1 -: 2];
        nib       = disp_q[(3 - idx) * 4 +: 4];
        blank     = 1'b0;
        case (idx)
            2'd0:    blank = (disp_q[15:12] == 4'd0);
            2'd1:    blank = (disp_q[15:8] == 8'd0);
            2'd2:    blank = (disp_q[15:4] == 12'd0);
            default: blank = 1'b0;
        endcase
        anode_nxt = 4'b1111 ^ (4'b1000 >> idx);
        led_nxt   = (BLANK_LZ && blank) ? 7'b1111111 : seg7(nib);
    end

    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            refresh_q <= '0;
            Anode     <= 4'b1111;
            LED_out   <= 7'b1111111;
        end else begin
            refresh_q <= refresh_q + REFRESH_BITS'(1);
            Anode     <= anode_nxt;
            LED_out   <= led_nxt;
        end
    end

endmodule
